// File: rtl/mem_pkg.sv
// mem_pkg: shared types and defaults for the mem_initiator self-test sweep.
//   - Default geometry (WIDTH_DEF, DEPTH_DEF, ADDR_WIDTH_DEF) and ERR_W.
//   - state_e: sweep FSM states. The second (inverted-pattern) write/read
//     pass states exist only when MEM_INIT_INV_PASS_EN is defined.
//   - Small state-classification helpers used by the FSM.
package mem_pkg;

    localparam int WIDTH_DEF      = 8;
    localparam int DEPTH_DEF      = 32;
    localparam int ADDR_WIDTH_DEF = $clog2(DEPTH_DEF);
    localparam int ERR_W          = ADDR_WIDTH_DEF + 2;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_REQ   = 4'd1,
        WR_WAIT  = 4'd2,
        RD_REQ   = 4'd3,
        RD_WAIT  = 4'd4,
`ifdef MEM_INIT_INV_PASS_EN
        WR2_REQ  = 4'd5,
        WR2_WAIT = 4'd6,
        RD2_REQ  = 4'd7,
        RD2_WAIT = 4'd8,
`endif
        DONE     = 4'd9
    } state_e;

    // States that put a request on the bus (valid high for one cycle).
    function automatic logic is_req(input state_e s);
        case (s)
            WR_REQ, RD_REQ: return 1'b1;
`ifdef MEM_INIT_INV_PASS_EN
            WR2_REQ, RD2_REQ: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Write-request states: wdata is loaded on entry.
    function automatic logic is_wr_req(input state_e s);
        case (s)
            WR_REQ: return 1'b1;
`ifdef MEM_INIT_INV_PASS_EN
            WR2_REQ: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // States where ready is sampled and the timeout counter runs.
    function automatic logic is_wait(input state_e s);
        case (s)
            WR_WAIT, RD_WAIT: return 1'b1;
`ifdef MEM_INIT_INV_PASS_EN
            WR2_WAIT, RD2_WAIT: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Read-wait states: rdata is compared against the expected pattern.
    function automatic logic is_rd_wait(input state_e s);
        case (s)
            RD_WAIT: return 1'b1;
`ifdef MEM_INIT_INV_PASS_EN
            RD2_WAIT: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

`ifdef MEM_INIT_INV_PASS_EN
    // Second-pass states use the inverted pattern.
    function automatic logic is_inv(input state_e s);
        case (s)
            WR2_REQ, WR2_WAIT, RD2_REQ, RD2_WAIT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
`endif

endpackage

// File: rtl/mem_init_pattern.sv
// mem_init_pattern: combinational sweep pattern generator.
//   pat = (addr zero-extended/truncated to WIDTH) ^ seed, optionally inverted.
// Ports:
//   addr_i   [ADDR_WIDTH-1:0]  word address
//   seed_i   [WIDTH-1:0]       latched sweep seed
//   invert_i                   1 = return the bitwise complement
//   pat_o    [WIDTH-1:0]       expected / write pattern
module mem_init_pattern #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      seed_i,
    input  logic                  invert_i,
    output logic [WIDTH-1:0]      pat_o
);

    logic [WIDTH-1:0] base_s;

    // Seeded address pattern with optional inversion.
    always_comb begin
        base_s = WIDTH'(addr_i) ^ seed_i;
        if (invert_i) begin
            pat_o = ~base_s;
        end else begin
            pat_o = base_s;
        end
    end

endmodule

// File: rtl/mem_initiator.sv
// mem_initiator: valid/ready initiator that runs a memory self-test sweep.
// On an accepted start it writes pat(a) to every address, reads every address
// back and compares, then reports pass/fail, a saturating error count and the
// first failing address. A WAIT state that sees no ready for TIMEOUT cycles
// aborts the sweep with timeout_err. Two cycles per transaction.
// Optional build macro MEM_INIT_INV_PASS_EN adds a second write+read pass with
// the inverted pattern; errors accumulate over both read passes.
// Ports:
//   clk, res (async active-low), start, seed      control inputs
//   valid, wr_rd, addr, wdata / rdata, ready      memory request interface
//   busy, done, pass, err_cnt, first_err_addr,
//   timeout_err                                   registered status
module mem_initiator
    import mem_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  start,
    input  logic [WIDTH-1:0]      seed,
    output logic                  valid,
    output logic                  wr_rd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH-1:0]      rdata,
    input  logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH+1:0] err_cnt,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  timeout_err
);

    localparam int EW = ADDR_WIDTH + 2;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      seed_q, seed_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_rd_q, wr_rd_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [EW-1:0]         err_q, err_d;
    logic [ADDR_WIDTH-1:0] ferr_q, ferr_d;
    logic                  tout_q, tout_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;

    logic [WIDTH-1:0]      pat_wr_s, pat_rd_s;
    logic                  inv_nxt_s, inv_cur_s;
    logic                  last_s;
    logic [ADDR_WIDTH-1:0] addr_inc_s;

`ifdef MEM_INIT_INV_PASS_EN
    assign inv_nxt_s = is_inv(state_d);
    assign inv_cur_s = is_inv(state_q);
`else
    assign inv_nxt_s = 1'b0;
    assign inv_cur_s = 1'b0;
`endif

    assign last_s     = (addr_q == ADDR_WIDTH'(DEPTH - 1));
    assign addr_inc_s = addr_q + ADDR_WIDTH'(1);

    // Write data for the request being issued on the next edge.
    mem_init_pattern #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_pat_wr (
        .addr_i   (addr_d),
        .seed_i   (seed_d),
        .invert_i (inv_nxt_s),
        .pat_o    (pat_wr_s)
    );

    // Expected read data for the address currently being waited on.
    mem_init_pattern #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_pat_rd (
        .addr_i   (addr_q),
        .seed_i   (seed_q),
        .invert_i (inv_cur_s),
        .pat_o    (pat_rd_s)
    );

    // Sweep FSM next-state, compare, timeout and status logic.
    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        addr_d  = addr_q;
        wr_rd_d = wr_rd_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        ferr_d  = ferr_q;
        tout_d  = tout_q;
        tcnt_d  = tcnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    seed_d  = seed;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = {EW{1'b0}};
                    ferr_d  = {ADDR_WIDTH{1'b0}};
                    tout_d  = 1'b0;
                    addr_d  = {ADDR_WIDTH{1'b0}};
                    wr_rd_d = 1'b1;
                    state_d = WR_REQ;
                end else begin
                    state_d = state_q;
                end
            end
            WR_REQ:  begin state_d = WR_WAIT; tcnt_d = {TW{1'b0}}; end
            RD_REQ:  begin state_d = RD_WAIT; tcnt_d = {TW{1'b0}}; end
            WR_WAIT: begin
                if (ready && last_s) begin
                    addr_d = {ADDR_WIDTH{1'b0}}; wr_rd_d = 1'b0; state_d = RD_REQ;
                end else if (ready) begin
                    addr_d = addr_inc_s; state_d = WR_REQ;
                end else begin
                    state_d = state_q;
                end
            end
            RD_WAIT: begin
                if (ready && last_s) begin
`ifdef MEM_INIT_INV_PASS_EN
                    addr_d = {ADDR_WIDTH{1'b0}}; wr_rd_d = 1'b1; state_d = WR2_REQ;
`else
                    state_d = DONE;
`endif
                end else if (ready) begin
                    addr_d = addr_inc_s; state_d = RD_REQ;
                end else begin
                    state_d = state_q;
                end
            end
`ifdef MEM_INIT_INV_PASS_EN
            WR2_REQ: begin state_d = WR2_WAIT; tcnt_d = {TW{1'b0}}; end
            RD2_REQ: begin state_d = RD2_WAIT; tcnt_d = {TW{1'b0}}; end
            WR2_WAIT: begin
                if (ready && last_s) begin
                    addr_d = {ADDR_WIDTH{1'b0}}; wr_rd_d = 1'b0; state_d = RD2_REQ;
                end else if (ready) begin
                    addr_d = addr_inc_s; state_d = WR2_REQ;
                end else begin
                    state_d = state_q;
                end
            end
            RD2_WAIT: begin
                if (ready && last_s) begin
                    state_d = DONE;
                end else if (ready) begin
                    addr_d = addr_inc_s; state_d = RD2_REQ;
                end else begin
                    state_d = state_q;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Abort when ready has been missing for TIMEOUT consecutive WAIT cycles.
        if (is_wait(state_q) && !ready) begin
            if (tcnt_q == TW'(TIMEOUT - 1)) begin
                tout_d  = 1'b1;
                state_d = DONE;
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end else begin
            tcnt_d = tcnt_d;
        end

        // err_q==0 means no earlier mismatch, so this one is the first.
        if (is_rd_wait(state_q) && ready && (rdata != pat_rd_s)) begin
            err_d = (err_q == {EW{1'b1}}) ? err_q : err_q + EW'(1);
            if (err_q == {EW{1'b0}}) begin
                ferr_d = addr_q;
            end else begin
                ferr_d = ferr_q;
            end
        end else begin
            err_d = err_d;
        end

        if ((state_d == DONE) && (state_q != DONE)) begin
            done_d = 1'b1;
            pass_d = (err_d == {EW{1'b0}}) && !tout_d;
        end else begin
            done_d = done_d;
        end

        valid_d = is_req(state_d);
        busy_d  = (state_d != IDLE) && (state_d != DONE);
    end

    // Load the write pattern on entry to a write request; hold otherwise.
    always_comb begin
        if (is_wr_req(state_d)) begin
            wdata_d = pat_wr_s;
        end else begin
            wdata_d = wdata_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= IDLE;
            seed_q  <= {WIDTH{1'b0}};
            addr_q  <= {ADDR_WIDTH{1'b0}};
            wr_rd_q <= 1'b0;
            wdata_q <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= {EW{1'b0}};
            ferr_q  <= {ADDR_WIDTH{1'b0}};
            tout_q  <= 1'b0;
            tcnt_q  <= {TW{1'b0}};
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            addr_q  <= addr_d;
            wr_rd_q <= wr_rd_d;
            wdata_q <= wdata_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
            tout_q  <= tout_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign valid          = valid_q;
    assign wr_rd          = wr_rd_q;
    assign addr           = addr_q;
    assign wdata          = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_q;
    assign first_err_addr = ferr_q;
    assign timeout_err    = tout_q;

endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: self-checking bench for mem_initiator with a behavioural
// memory responder (registered ready, optional random latency, read-side
// stuck faults) and a reference model of the expected sweep result.
module tb_mem_initiator;
    import mem_pkg::*;

    localparam int W  = WIDTH_DEF;
    localparam int D  = DEPTH_DEF;
    localparam int AW = ADDR_WIDTH_DEF;
    localparam int TO = 15;
`ifdef MEM_INIT_INV_PASS_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif
    localparam int SWEEP_CYC = 4 * D * NPASS;

    logic             clk = 1'b0;
    logic             res = 1'b0;
    logic             start = 1'b0;
    logic [W-1:0]     seed = '0;
    logic             valid, wr_rd, busy, done, pass, timeout_err;
    logic [AW-1:0]    addr, first_err_addr;
    logic [W-1:0]     wdata;
    logic [W-1:0]     rdata = '0;
    logic             ready = 1'b0;
    logic [ERR_W-1:0] err_cnt;
    logic [30:0]      outs_w;

    assign outs_w = {valid, wr_rd, addr, wdata, busy, done, pass, err_cnt, first_err_addr, timeout_err};

    always #5 clk = ~clk;

    mem_initiator #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .res(res), .start(start), .seed(seed),
        .valid(valid), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err_addr(first_err_addr), .timeout_err(timeout_err)
    );

    // Responder model state
    logic [W-1:0] mem     [D];
    logic         flt_en  [D];
    logic [W-1:0] flt_val [D];
    logic         rsp_dis = 1'b0;
    int           max_lat = 0;
    int           pend = 0;
    int           vcnt = 0;
    int           dup_cnt = 0;
    logic         valid_prev = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // Memory responder: registered ready, read faults applied on the read side.
    always @(posedge clk or negedge res) begin
        if (!res) begin
            ready <= 1'b0; pend <= 0; valid_prev <= 1'b0;
        end else begin
            ready <= 1'b0;
            valid_prev <= valid;
            if (valid) begin
                vcnt <= vcnt + 1;
                if (valid_prev) dup_cnt <= dup_cnt + 1;
                if (wr_rd) mem[addr] <= wdata;
                else rdata <= flt_en[addr] ? flt_val[addr] : mem[addr];
                if (rsp_dis) pend <= 0;
                else if (max_lat == 0) ready <= 1'b1;
                else pend <= $urandom_range(max_lat, 0) + 1;
            end else if (pend == 1) begin
                ready <= 1'b1; pend <= 0;
            end else if (pend > 1) begin
                pend <= pend - 1;
            end
        end
    end

    task automatic clear_faults();
        for (int a = 0; a < D; a++) begin flt_en[a] = 1'b0; flt_val[a] = '0; end
    endtask

    // Reference: which reads mismatch, in sweep order, over all read passes.
    task automatic model_sweep(input logic [W-1:0] s, output int e_err, output int e_first, output logic e_pass);
        logic [W-1:0] p;
        bit seen;
        seen = 0; e_err = 0; e_first = 0;
        for (int ps = 0; ps < NPASS; ps++) begin
            for (int a = 0; a < D; a++) begin
                p = W'(a) ^ s;
                if (ps == 1) p = ~p;
                if (flt_en[a] && (flt_val[a] != p)) begin
                    if (!seen) e_first = a;
                    seen = 1; e_err++;
                end
            end
        end
        if (e_err > (2 ** ERR_W) - 1) e_err = (2 ** ERR_W) - 1;
        e_pass = (e_err == 0);
    endtask

    // Number of addresses whose final contents differ from the last pass written.
    function automatic int mem_diffs(input logic [W-1:0] s);
        logic [W-1:0] p;
        int n;
        n = 0;
        for (int a = 0; a < D; a++) begin
            p = W'(a) ^ s;
            if (NPASS == 2) p = ~p;
            if (mem[a] !== p) n++;
        end
        return n;
    endfunction

    // Called #1 after a posedge; returns #1 after the edge that samples start.
    task automatic do_start(input logic [W-1:0] s);
        start = 1'b1; seed = s;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit ok);
        cyc = 0; ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (outs_w !== 31'd0) begin n_bad++; $display("FAIL reset_outputs got=%h exp=0", outs_w); end
        @(negedge clk); res = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (outs_w !== 31'd0) begin n_bad++; $display("FAIL idle_outputs got=%h exp=0", outs_w); end
    endtask

    // Clean sweep, single stuck fault at 5, faults at 3/9/20.
    task automatic test_faults();
        int cyc, e_err, e_first, v0;
        bit ok;
        logic e_pass;
        logic [W-1:0] s;
        s = 8'hA5;
        for (int sc = 0; sc < 3; sc++) begin
            clear_faults();
            if (sc == 1) begin flt_en[5] = 1'b1; flt_val[5] = 8'h00; end
            if (sc == 2) begin
                flt_en[3]  = 1'b1; flt_val[3]  = (8'd3 ^ s) ^ 8'h01;
                flt_en[9]  = 1'b1; flt_val[9]  = (8'd9 ^ s) ^ 8'h01;
                flt_en[20] = 1'b1; flt_val[20] = (8'd20 ^ s) ^ 8'h01;
            end
            model_sweep(s, e_err, e_first, e_pass);
            v0 = vcnt;
            do_start(s);
            wait_done(cyc, ok);
            n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL sc%0d_done_seen got=%0d exp=1", sc, ok); end
            n_cmp++; if (cyc !== SWEEP_CYC) begin n_bad++; $display("FAIL sc%0d_done_cycle got=%0d exp=%0d", sc, cyc, SWEEP_CYC); end
            n_cmp++; if (err_cnt !== ERR_W'(e_err)) begin n_bad++; $display("FAIL sc%0d_err_cnt got=%0d exp=%0d", sc, err_cnt, e_err); end
            n_cmp++; if (first_err_addr !== AW'(e_first)) begin n_bad++; $display("FAIL sc%0d_first_err got=%0d exp=%0d", sc, first_err_addr, e_first); end
            n_cmp++; if (pass !== e_pass) begin n_bad++; $display("FAIL sc%0d_pass got=%0d exp=%0d", sc, pass, e_pass); end
            n_cmp++; if ({busy, timeout_err} !== 2'b00) begin n_bad++; $display("FAIL sc%0d_busy_tout got=%b exp=00", sc, {busy, timeout_err}); end
            n_cmp++; if (mem_diffs(s) !== 0) begin n_bad++; $display("FAIL sc%0d_mem_contents got=%0d exp=0 bad words", sc, mem_diffs(s)); end
            n_cmp++; if ((vcnt - v0) !== 2 * D * NPASS) begin n_bad++; $display("FAIL sc%0d_valid_pulses got=%0d exp=%0d", sc, vcnt - v0, 2 * D * NPASS); end
        end
        n_cmp++; if (dup_cnt !== 0) begin n_bad++; $display("FAIL back_to_back_valid got=%0d exp=0", dup_cnt); end
        clear_faults();
    endtask

    // Restart from DONE clears status at once and runs a fresh sweep.
    task automatic test_restart_from_done();
        int cyc;
        bit ok;
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL restart_pre_done got=%0d exp=1", done); end
        do_start(8'h3C);
        n_cmp++;
        if ({busy, done, pass, err_cnt, first_err_addr, timeout_err} !== {1'b1, 1'b0, 1'b0, {ERR_W{1'b0}}, {AW{1'b0}}, 1'b0}) begin
            n_bad++; $display("FAIL restart_clear got=%b exp=busy only", {busy, done, pass, err_cnt, first_err_addr, timeout_err});
        end
        wait_done(cyc, ok);
        n_cmp++; if ({ok, pass} !== 2'b11) begin n_bad++; $display("FAIL restart_pass got=%b exp=11", {ok, pass}); end
        n_cmp++; if (mem_diffs(8'h3C) !== 0) begin n_bad++; $display("FAIL restart_mem got=%0d exp=0 bad words", mem_diffs(8'h3C)); end
    endtask

    task automatic test_timeout();
        int cyc, v0;
        bit ok;
        rsp_dis = 1'b1;
        v0 = vcnt;
        do_start(8'h5A);
        wait_done(cyc, ok);
        n_cmp++; if (cyc !== 1 + TO) begin n_bad++; $display("FAIL timeout_cycle got=%0d exp=%0d", cyc, 1 + TO); end
        n_cmp++; if ({timeout_err, pass, busy} !== 3'b100) begin n_bad++; $display("FAIL timeout_status got=%b exp=100", {timeout_err, pass, busy}); end
        n_cmp++; if ((vcnt - v0) !== 1) begin n_bad++; $display("FAIL timeout_valid_pulses got=%0d exp=1", vcnt - v0); end
        n_cmp++; if (addr !== '0) begin n_bad++; $display("FAIL timeout_addr got=%0d exp=0", addr); end
        rsp_dis = 1'b0;
    endtask

    task automatic test_reset_mid_sweep();
        int cyc;
        bit ok;
        do_start(8'h77);
        repeat (40) @(posedge clk);
        #2 res = 1'b0;
        #1;
        n_cmp++; if (outs_w !== 31'd0) begin n_bad++; $display("FAIL midreset_outputs got=%h exp=0", outs_w); end
        @(posedge clk); #1;
        n_cmp++; if (outs_w !== 31'd0) begin n_bad++; $display("FAIL midreset_held got=%h exp=0", outs_w); end
        res = 1'b1;
        @(posedge clk); #1;
        do_start(8'h77);
        wait_done(cyc, ok);
        n_cmp++; if (cyc !== SWEEP_CYC) begin n_bad++; $display("FAIL midreset_resweep_cycle got=%0d exp=%0d", cyc, SWEEP_CYC); end
        n_cmp++; if ({pass, err_cnt} !== {1'b1, {ERR_W{1'b0}}}) begin n_bad++; $display("FAIL midreset_resweep_pass got=%b exp=1/0", {pass, err_cnt}); end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        bit ok;
        do_start(8'hA5);
        repeat (8) @(posedge clk);
        #1 start = 1'b1; seed = 8'h11;
        @(posedge clk); #1 start = 1'b0;
        wait_done(cyc, ok);
        n_cmp++; if (cyc + 9 !== SWEEP_CYC) begin n_bad++; $display("FAIL busy_start_cycle got=%0d exp=%0d", cyc + 9, SWEEP_CYC); end
        n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL busy_start_pass got=%0d exp=1", pass); end
        n_cmp++; if (mem_diffs(8'hA5) !== 0) begin n_bad++; $display("FAIL busy_start_seed_kept got=%0d exp=0 bad words", mem_diffs(8'hA5)); end
    endtask

    // Random seeds, random faults, random responder latency.
    task automatic test_random();
        int cyc, e_err, e_first, nf, a;
        bit ok;
        logic e_pass;
        logic [W-1:0] s;
        for (int it = 0; it < 6; it++) begin
            clear_faults();
            s = W'($urandom);
            nf = $urandom_range(4, 0);
            for (int k = 0; k < nf; k++) begin
                a = $urandom_range(D - 1, 0);
                flt_en[a] = 1'b1; flt_val[a] = W'($urandom);
            end
            max_lat = (it < 2) ? 0 : $urandom_range(6, 1);
            model_sweep(s, e_err, e_first, e_pass);
            do_start(s);
            wait_done(cyc, ok);
            n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_done_seen got=%0d exp=1", it, ok); end
            if (max_lat == 0) begin
                n_cmp++; if (cyc !== SWEEP_CYC) begin n_bad++; $display("FAIL rnd%0d_cycle got=%0d exp=%0d", it, cyc, SWEEP_CYC); end
            end
            n_cmp++; if (err_cnt !== ERR_W'(e_err)) begin n_bad++; $display("FAIL rnd%0d_err_cnt got=%0d exp=%0d", it, err_cnt, e_err); end
            n_cmp++; if (first_err_addr !== AW'(e_first)) begin n_bad++; $display("FAIL rnd%0d_first_err got=%0d exp=%0d", it, first_err_addr, e_first); end
            n_cmp++; if ({pass, timeout_err} !== {e_pass, 1'b0}) begin n_bad++; $display("FAIL rnd%0d_pass_tout got=%b exp=%b0", it, {pass, timeout_err}, e_pass); end
            n_cmp++; if (mem_diffs(s) !== 0) begin n_bad++; $display("FAIL rnd%0d_mem got=%0d exp=0 bad words", it, mem_diffs(s)); end
        end
        max_lat = 0;
        clear_faults();
    endtask

    initial begin
        clear_faults();
        for (int a = 0; a < D; a++) mem[a] = '0;
        test_reset();
        test_faults();
        test_restart_from_done();
        test_timeout();
        test_reset_mid_sweep();
        test_start_while_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Initiator end of the valid/ready single-port memory interface used by the `mem` responder.
- On a start pulse, it performs a self-test sweep: it writes a seeded pattern to every address, then reads every address back and compares.
- It reports pass/fail, an error count and the first failing address to the surrounding test/control logic.

Parameters:
- WIDTH, 8, data width; must match the responder.
- DEPTH, 32, number of words swept.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- TIMEOUT, 15, maximum cycles to wait for ready before aborting.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- res  in  1  reset; asynchronous, active-low.
- start  in  1  single-cycle request to begin a sweep.
- seed  in  WIDTH  pattern seed; sampled on the accepted start.
- valid  out  1  request to the memory.
- wr_rd  out  1  1 = write, 0 = read.
- addr  out  ADDR_WIDTH  request address.
- wdata  out  WIDTH  write data.
- rdata  in  WIDTH  read data from the memory.
- ready  in  1  memory acknowledge; registered by the responder.
- busy  out  1  sweep in progress.
- done  out  1  sweep finished; held until the next accepted start.
- pass  out  1  valid when done=1; 1 = no mismatch and no timeout.
- err_cnt  out  ADDR_WIDTH+2  saturating mismatch count.
- first_err_addr  out  ADDR_WIDTH  address of the first mismatch; 0 if none.
- timeout_err  out  1  sweep aborted because ready was not seen.

Behaviour:
- Reset (res=0, async): all outputs 0, state IDLE, latched seed 0, timeout counter 0. Reset mid-sweep aborts immediately; valid drops without waiting for ready.
- All outputs are registered.
- Expected pattern: pat(a) = zero-extended or truncated a, XOR the latched seed, WIDTH bits.
- States: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE.
  - IDLE or DONE, start=1: latch seed; clear done, pass, err_cnt, first_err_addr, timeout_err; set addr=0; go to WR_REQ; busy=1.
  - start while busy=1: ignored.
  - WR_REQ: valid=1, wr_rd=1, wdata=pat(addr); next edge goes to WR_WAIT with valid=0.
  - WR_WAIT: if ready=1, then:
    - if addr==DEPTH-1, set addr=0 and go to RD_REQ;
    - else increment addr and go to WR_REQ.
  - RD_REQ: valid=1, wr_rd=0; next edge goes to RD_WAIT with valid=0.
  - RD_WAIT: if ready=1, compare rdata with pat(addr):
    - on mismatch, increment err_cnt (saturating at all-ones);
    - if this is the first mismatch, capture first_err_addr=addr;
    - if addr==DEPTH-1, go to DONE; else increment addr and go to RD_REQ.
  - DONE: busy=0, done=1, pass=(err_cnt==0 && !timeout_err).
- Throughput: 2 cycles per transaction. done rises 4*DEPTH cycles after the edge that samples start (128 for defaults).
- Handshake: valid is a one-cycle pulse per transaction, so the responder never sees back-to-back duplicate accesses. ready is only sampled in the WAIT states; ready outside those states is ignored.
- Timeout: the counter clears on entry to each WAIT state and increments each WAIT cycle without ready. When the count reaches TIMEOUT, set timeout_err=1, go to DONE, pass=0.
- wr_rd, addr and wdata hold their last values while valid=0.

Optional Feature:
- MEM_INIT_INV_PASS_EN
  - Defined: after the read pass, perform a second write pass and a second read pass with pattern ~pat(a). err_cnt accumulates across both read passes. first_err_addr is from the earliest mismatch. done rises after 8*DEPTH cycles.
  - Undefined: single write pass and single read pass only.

Decomposition:
- Package mem_pkg holds the state enum (including the INV pass states when enabled) and the localparam ERR_W=ADDR_WIDTH+2.
- Sub-module mem_init_pattern: combinational pat(addr, seed, invert) generator, shared with bench scoreboards.

Test Plan:
- Clean sweep with the responder, seed=8'hA5:
  - 32 writes, mem[a]=a^8'hA5;
  - 32 reads;
  - done at 128 cycles after start;
  - pass=1, err_cnt=0.
- Fault injection: bench forces mem[5] to 8'h00 between the write and read passes → err_cnt=1, first_err_addr=5, pass=0.
- Mismatches at addrs 3, 9 and 20 → err_cnt=3, first_err_addr=3.
- ready tied to 0 → valid pulses once at addr 0; done after 1+TIMEOUT cycles; timeout_err=1, pass=0, busy=0.
- Async reset at cycle 40 of a sweep → outputs 0 immediately, state IDLE. A new start runs a full clean sweep to pass=1.
- start pulsed at cycle 10 while busy → no effect; done still at 128.
- start in DONE with seed=8'h3C → status clears and a new sweep runs.
- MEM_INIT_INV_PASS_EN defined, seed=8'h00 → second write pass writes ~a; done at 256 cycles; pass=1.
